mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 194 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle processor control FSM (optional halt: MC_CTRL_HALT_EN)
module mc_control_fsm #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [31:0] x17_val,
  input  logic        bcond,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_source,
  output logic        is_ecall,
  output logic        halted,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IF     = 3'd0;
  localparam logic [2:0] S_ID     = 3'd1;
  localparam logic [2:0] S_EX     = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_PC_INC = 3'd5;
  localparam logic [2:0] S_JUMP   = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // Final beat of a memory phase; cnt counts 0..MEM_LATENCY-1.
  localparam logic [3:0] LAST_BEAT = 4'(MEM_LATENCY - 1);

  logic [2:0] state_q;
  logic [2:0] next_state;
  logic [3:0] cnt;
  logic       last_beat;
  logic       halt_req;
  logic       is_jump_link;

  assign last_beat    = (cnt == LAST_BEAT);
  assign is_ecall     = (opcode == OP_SYS);
  assign is_jump_link = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign state        = state_q;

`ifdef MC_CTRL_HALT_EN
  logic halted_q;

  assign halt_req = (x17_val == 32'd10);
  assign halted   = halted_q;

  // Halted flag follows entry into HALT and holds until reset.
  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= (next_state == S_HALT);
  end
`else
  logic unused_x17;

  assign unused_x17 = ^x17_val;
  assign halt_req   = 1'b0;
  assign halted     = 1'b0;
`endif

  // State register and memory-phase latency counter; cnt is zero whenever a phase is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      cnt     <= 4'd0;
    end else begin
      state_q <= next_state;
      if ((state_q == S_IF || state_q == S_MEM) && !last_beat) cnt <= cnt + 4'd1;
      else                                                     cnt <= 4'd0;
    end
  end

  // Next-state and per-state control decode; strobes are forced low while reset is held.
  always_comb begin
    next_state = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (last_beat) begin
          ir_write   = 1'b1;
          next_state = S_ID;
        end
      end

      S_ID: begin
        alu_src_b = 2'b10;
        if (is_ecall) next_state = halt_req ? S_HALT : S_PC_INC;
        else          next_state = S_EX;
      end

      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end
          OP_JAL: begin
            alu_src_b  = 2'b10;
            next_state = S_WB;
          end
          OP_JALR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = S_WB;
          end
          OP_BR: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            next_state = bcond ? S_JUMP : S_PC_INC;
          end
          default: next_state = S_PC_INC;
        endcase
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (last_beat) next_state = (opcode == OP_LOAD) ? S_WB : S_PC_INC;
      end

      S_WB: begin
        reg_write = 1'b1;
        if (opcode == OP_LOAD)  wb_sel = 2'b01;
        else if (is_jump_link)  wb_sel = 2'b10;
        next_state = is_jump_link ? S_JUMP : S_PC_INC;
      end

      S_PC_INC: begin
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        next_state = S_IF;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        next_state = S_IF;
      end

      default: next_state = S_HALT;
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm (latency 4 and latency 1 instances)
module tb_mc_control_fsm;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_PC_INC = 3'd5, S_JUMP = 3'd6, S_HALT = 3'd7;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BR = 7'b1100011, OP_SYS = 7'b1110011, OP_LUI = 7'b0110111;
`ifdef MC_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       is_ecall;
    logic       halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [31:0] x17_val = 32'd0;
  logic        bcond = 1'b0;

  logic        a_pcw, a_irw, a_iod, a_mr, a_mw, a_rw, a_asa, a_pcs, a_ec, a_h;
  logic [1:0]  a_wbs, a_asb, a_op;
  logic [2:0]  a_st;
  logic        b_pcw, b_irw, b_iod, b_mr, b_mw, b_rw, b_asa, b_pcs, b_ec, b_h;
  logic [1:0]  b_wbs, b_asb, b_op;
  logic [2:0]  b_st;

  exp_t act4, act1;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .x17_val(x17_val), .bcond(bcond),
    .pc_write(a_pcw), .ir_write(a_irw), .i_or_d(a_iod), .mem_read(a_mr), .mem_write(a_mw),
    .reg_write(a_rw), .wb_sel(a_wbs), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_op),
    .pc_source(a_pcs), .is_ecall(a_ec), .halted(a_h), .state(a_st)
  );

  mc_control_fsm #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .x17_val(x17_val), .bcond(bcond),
    .pc_write(b_pcw), .ir_write(b_irw), .i_or_d(b_iod), .mem_read(b_mr), .mem_write(b_mw),
    .reg_write(b_rw), .wb_sel(b_wbs), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_op),
    .pc_source(b_pcs), .is_ecall(b_ec), .halted(b_h), .state(b_st)
  );

  assign act4 = {a_st, a_pcw, a_irw, a_iod, a_mr, a_mw, a_rw, a_wbs, a_asa, a_asb, a_op, a_pcs, a_ec, a_h};
  assign act1 = {b_st, b_pcw, b_irw, b_iod, b_mr, b_mw, b_rw, b_wbs, b_asa, b_asb, b_op, b_pcs, b_ec, b_h};

  function automatic exp_t base(input logic [2:0] st, input logic ec);
    exp_t e;
    e = '0;
    e.st = st;
    e.is_ecall = ec;
    return e;
  endfunction

  // Reference model: expected per-cycle trace of one instruction, from the control table.
  task automatic push_trace(input logic [6:0] op, input logic bc, input logic [31:0] x, input int lat);
    exp_t e;
    logic ec;
    logic [2:0] nxt;
    ec = (op == OP_SYS);
    for (int i = 0; i < lat; i++) begin
      e = base(S_IF, ec); e.mem_read = 1'b1; e.ir_write = (i == lat - 1);
      sb_q.push_back(e);
    end
    e = base(S_ID, ec); e.alu_src_b = 2'b10;
    sb_q.push_back(e);
    if (ec) begin
      if (HALT_EN && x == 32'd10) begin
        for (int i = 0; i < 4; i++) begin
          e = base(S_HALT, ec); e.halted = 1'b1;
          sb_q.push_back(e);
        end
        return;
      end
      nxt = S_PC_INC;
    end else begin
      e = base(S_EX, ec);
      nxt = S_WB;
      if (op == OP_R)                          begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      else if (op == OP_I)                     begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
      else if (op == OP_LOAD || op == OP_STORE) begin e.alu_src_a = 1; e.alu_src_b = 2'b10; nxt = S_MEM; end
      else if (op == OP_JAL)                   begin e.alu_src_b = 2'b10; end
      else if (op == OP_JALR)                  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      else if (op == OP_BR)                    begin e.alu_src_a = 1; e.alu_op = 2'b01; nxt = bc ? S_JUMP : S_PC_INC; end
      else                                     nxt = S_PC_INC;
      sb_q.push_back(e);
      if (nxt == S_MEM) begin
        for (int i = 0; i < lat; i++) begin
          e = base(S_MEM, ec); e.i_or_d = 1; e.mem_read = (op == OP_LOAD); e.mem_write = (op == OP_STORE);
          sb_q.push_back(e);
        end
        nxt = (op == OP_LOAD) ? S_WB : S_PC_INC;
      end
      if (nxt == S_WB) begin
        e = base(S_WB, ec); e.reg_write = 1;
        e.wb_sel = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
        sb_q.push_back(e);
        nxt = (op == OP_JAL || op == OP_JALR) ? S_JUMP : S_PC_INC;
      end
    end
    e = base(nxt, ec); e.pc_write = 1;
    if (nxt == S_PC_INC) e.alu_src_b = 2'b01;
    else                 e.pc_source = 1'b1;
    sb_q.push_back(e);
  endtask

  // Drive one instruction from its first IF cycle and check each cycle against the scoreboard.
  task automatic run_instr(input string name, input logic [6:0] op, input logic bc,
                           input logic [31:0] x, input int lat);
    exp_t e, a;
    int cyc;
    opcode = op; bcond = bc; x17_val = x;
    push_trace(op, bc, x, lat);
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      a = (lat == 1) ? act1 : act4;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (a_st !== S_IF || b_st !== S_IF || a_h !== 1'b0 || b_h !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got st=%0d/%0d halted=%b/%b expected st=0/0 halted=0/0", a_st, b_st, a_h, b_h);
    end
    tests++;
    if ({a_pcw, a_irw, a_mr, a_mw, a_rw} !== 5'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 00000", {a_pcw, a_irw, a_mr, a_mw, a_rw});
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_alu_ops();
    apply_reset();
    run_instr("rtype", OP_R, 1'b0, 32'd0, 4);
    apply_reset();
    run_instr("itype", OP_I, 1'b0, 32'd0, 4);
    apply_reset();
    run_instr("jalr", OP_JALR, 1'b0, 32'd0, 4);
    apply_reset();
    run_instr("other_op", OP_LUI, 1'b0, 32'd0, 4);
  endtask

  task automatic test_load_store();
    apply_reset();
    run_instr("load", OP_LOAD, 1'b0, 32'd0, 4);
    apply_reset();
    run_instr("store", OP_STORE, 1'b0, 32'd0, 4);
  endtask

  task automatic test_branch();
    apply_reset();
    run_instr("branch_taken", OP_BR, 1'b1, 32'd0, 4);
    apply_reset();
    run_instr("branch_not_taken", OP_BR, 1'b0, 32'd0, 4);
  endtask

  task automatic test_latency_one();
    apply_reset();
    run_instr("jal_lat1", OP_JAL, 1'b0, 32'd0, 1);
    apply_reset();
    run_instr("load_lat1", OP_LOAD, 1'b0, 32'd0, 1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_instr("b2b_r", OP_R, 1'b0, 32'd0, 4);
    run_instr("b2b_br", OP_BR, 1'b1, 32'd0, 4);
    run_instr("b2b_store", OP_STORE, 1'b0, 32'd0, 4);
    run_instr("b2b_jal", OP_JAL, 1'b0, 32'd0, 4);
  endtask

  task automatic test_ecall();
    apply_reset();
    run_instr("ecall_x10", OP_SYS, 1'b0, 32'd10, 4);
    apply_reset();
    run_instr("ecall_x5", OP_SYS, 1'b0, 32'd5, 4);
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    opcode = OP_LOAD; bcond = 1'b0; x17_val = 32'd0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    tests++;
    if (a_st !== S_MEM || a_mr !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_setup: got st=%0d mem_read=%b expected st=3 mem_read=1", a_st, a_mr);
    end
    apply_reset();
    run_instr("after_mid_reset", OP_R, 1'b0, 32'd0, 4);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_latency_one();
    test_back_to_back();
    test_ecall();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
